// File: rtl/jogo_pkg.sv
// Shared state codes for the game sequencer and the hex display decoder,
// plus the bundle of datapath strobes the sequencer decodes from its state.
package jogo_pkg;

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] INICIO_RODADA  = 4'h2;
    localparam logic [3:0] MOSTRA         = 4'h3;
    localparam logic [3:0] PROXIMA_MOSTRA = 4'h4;
    localparam logic [3:0] INICIA_ESPERA  = 4'h5;
    localparam logic [3:0] ESPERA_JOGADA  = 4'h6;
    localparam logic [3:0] REGISTRA       = 4'h7;
    localparam logic [3:0] COMPARACAO     = 4'h8;
    localparam logic [3:0] PROXIMA_RODADA = 4'h9;
    localparam logic [3:0] FIM_GANHOU     = 4'hA;
    localparam logic [3:0] PROXIMA_JOGADA = 4'hB;
    localparam logic [3:0] FIM_TIMEOUT    = 4'hD;
    localparam logic [3:0] FIM_PERDEU     = 4'hE;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_r;
        logic conta_r;
        logic registra_r;
        logic zera_t;
        logic conta_t;
        logic zera_m;
        logic conta_m;
        logic leds_sel;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } saida_t;

endpackage

// File: rtl/sequenciador_jogo_if.sv
// Control/status bundle between the game sequencer (master) and its datapath (slave).
interface sequenciador_jogo_if;

    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       fimR;
    logic       timeout;
    logic       fimM;

    logic       zeraE;
    logic       contaE;
    logic       zeraR;
    logic       contaR;
    logic       registraR;
    logic       zeraT;
    logic       contaT;
    logic       zeraM;
    logic       contaM;
    logic       leds_sel;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualRodada, fimR, timeout, fimM,
        output zeraE, contaE, zeraR, contaR, registraR, zeraT, contaT, zeraM, contaM,
        output leds_sel, pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualRodada, fimR, timeout, fimM,
        input  zeraE, contaE, zeraR, contaR, registraR, zeraT, contaT, zeraM, contaM,
        input  leds_sel, pronto, ganhou, perdeu, db_timeout, db_estado
    );

endinterface

// File: rtl/sequenciador_jogo.sv
// Moore control FSM of the memory game: shows the growing sequence, waits for
// the player's moves, compares them and reports win, loss or timeout.
module sequenciador_jogo
    import jogo_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    sequenciador_jogo_if.master bus
);

    logic [3:0] estado;
    logic [3:0] proximo;
    saida_t     saida;

    // NOTE: sequential state uses non-blocking assignment; reset is in the sensitivity list so it acts without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIO_RODADA;
            INICIO_RODADA:  proximo = MOSTRA;
            MOSTRA:         proximo = bus.fimM ? PROXIMA_MOSTRA : MOSTRA;
            PROXIMA_MOSTRA: proximo = bus.enderecoIgualRodada ? INICIA_ESPERA : MOSTRA;
            INICIA_ESPERA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (bus.jogada)       proximo = REGISTRA;
                else if (bus.timeout) proximo = FIM_TIMEOUT;
                else                  proximo = ESPERA_JOGADA;
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual)                    proximo = FIM_PERDEU;
                else if (!bus.enderecoIgualRodada) proximo = PROXIMA_JOGADA;
                else if (!bus.fimR)                proximo = PROXIMA_RODADA;
                else                               proximo = FIM_GANHOU;
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIO_RODADA;
            FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU:
                            proximo = bus.iniciar ? PREPARACAO : estado;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        saida = '0;
        case (estado)
            PREPARACAO: begin
                saida.zera_e = 1'b1;
                saida.zera_r = 1'b1;
                saida.zera_t = 1'b1;
                saida.zera_m = 1'b1;
            end
            INICIO_RODADA: begin
                saida.zera_e = 1'b1;
                saida.zera_m = 1'b1;
            end
            MOSTRA: begin
                saida.leds_sel = 1'b1;
                saida.conta_m  = 1'b1;
            end
            // contaE stays Moore: the extra increment on the last shown word is cleared by inicia_espera.
            PROXIMA_MOSTRA: begin
                saida.zera_m  = 1'b1;
                saida.conta_e = 1'b1;
            end
            INICIA_ESPERA: begin
                saida.zera_e = 1'b1;
                saida.zera_t = 1'b1;
            end
            ESPERA_JOGADA:  saida.conta_t    = 1'b1;
            REGISTRA:       saida.registra_r = 1'b1;
            PROXIMA_JOGADA: begin
                saida.conta_e = 1'b1;
                saida.zera_t  = 1'b1;
            end
            PROXIMA_RODADA: saida.conta_r = 1'b1;
            FIM_GANHOU: begin
                saida.pronto = 1'b1;
                saida.ganhou = 1'b1;
            end
            FIM_PERDEU: begin
                saida.pronto = 1'b1;
                saida.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                saida.pronto     = 1'b1;
                saida.perdeu     = 1'b1;
                saida.db_timeout = 1'b1;
            end
            default: saida = '0;
        endcase
    end

    assign bus.zeraE      = saida.zera_e;
    assign bus.contaE     = saida.conta_e;
    assign bus.zeraR      = saida.zera_r;
    assign bus.contaR     = saida.conta_r;
    assign bus.registraR  = saida.registra_r;
    assign bus.zeraT      = saida.zera_t;
    assign bus.contaT     = saida.conta_t;
    assign bus.zeraM      = saida.zera_m;
    assign bus.contaM     = saida.conta_m;
    assign bus.leds_sel   = saida.leds_sel;
    assign bus.pronto     = saida.pronto;
    assign bus.ganhou     = saida.ganhou;
    assign bus.perdeu     = saida.perdeu;
    assign bus.db_timeout = saida.db_timeout;
    assign bus.db_estado  = estado;

endmodule

// File: tb/tb_sequenciador_jogo.sv
// Bench for sequenciador_jogo: a behavioural game model plus a small datapath
// model drive the inputs; every cycle the DUT state and strobes are compared.
module tb_sequenciador_jogo;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sequenciador_jogo_if bus ();

    sequenciador_jogo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Strobe bit positions, MSB first: zeraE contaE zeraR contaR registraR zeraT contaT zeraM contaM leds_sel pronto ganhou perdeu db_timeout
    localparam logic [13:0] B_ZE  = 14'h2000;
    localparam logic [13:0] B_CE  = 14'h1000;
    localparam logic [13:0] B_ZR  = 14'h0800;
    localparam logic [13:0] B_CR  = 14'h0400;
    localparam logic [13:0] B_RR  = 14'h0200;
    localparam logic [13:0] B_ZT  = 14'h0100;
    localparam logic [13:0] B_CT  = 14'h0080;
    localparam logic [13:0] B_ZM  = 14'h0040;
    localparam logic [13:0] B_CM  = 14'h0020;
    localparam logic [13:0] B_LED = 14'h0010;
    localparam logic [13:0] B_PR  = 14'h0008;
    localparam logic [13:0] B_GA  = 14'h0004;
    localparam logic [13:0] B_PE  = 14'h0002;
    localparam logic [13:0] B_TO  = 14'h0001;

    int tests = 0;
    int fails = 0;

    int m_state = 0;
    int addr    = 0;
    int rnd     = 0;
    int mtim    = 0;

    int play_mode = 0;   // 0 never play, 1 random plays, 2 only timeout, 3 play and timeout together
    bit rnd_mode  = 1'b0;
    int fail_r    = -1;
    int fail_a    = -1;
    int d_cr      = 0;
    int base      = 0;
    int seq [7]   = '{1, 2, 3, 3, 3, 4, 5};

    logic [13:0] dut_o;
    assign dut_o = {bus.zeraE, bus.contaE, bus.zeraR, bus.contaR, bus.registraR,
                    bus.zeraT, bus.contaT, bus.zeraM, bus.contaM, bus.leds_sel,
                    bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};

    function automatic logic [13:0] exp_mask(input int s);
        case (s)
            1:  return B_ZE | B_ZR | B_ZT | B_ZM;
            2:  return B_ZE | B_ZM;
            3:  return B_LED | B_CM;
            4:  return B_ZM | B_CE;
            5:  return B_ZE | B_ZT;
            6:  return B_CT;
            7:  return B_RR;
            9:  return B_CR;
            10: return B_PR | B_GA;
            11: return B_CE | B_ZT;
            13: return B_PR | B_PE | B_TO;
            14: return B_PR | B_PE;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_next(input int s, input logic ini, jog, ig, eir, fr, to, fm);
        case (s)
            0:          return ini ? 1 : 0;
            1:          return 2;
            2:          return 3;
            3:          return fm ? 4 : 3;
            4:          return eir ? 5 : 3;
            5:          return 6;
            6:          return jog ? 7 : (to ? 13 : 6);
            7:          return 8;
            8:          return !ig ? 14 : (!eir ? 11 : (!fr ? 9 : 10));
            9:          return 2;
            11:         return 6;
            10, 13, 14: return ini ? 1 : s;
            default:    return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (bus.db_estado !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, bus.db_estado, s);
    endtask

    // Game model and the datapath counters it implies.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            addr    <= 0;
            rnd     <= 0;
            mtim    <= 0;
        end else begin
            if ((exp_mask(m_state) & B_ZE) != 0)      addr <= 0;
            else if ((exp_mask(m_state) & B_CE) != 0) addr <= addr + 1;
            if ((exp_mask(m_state) & B_ZR) != 0)      rnd <= 0;
            else if ((exp_mask(m_state) & B_CR) != 0) rnd <= rnd + 1;
            if ((exp_mask(m_state) & B_ZM) != 0)      mtim <= 0;
            else if ((exp_mask(m_state) & B_CM) != 0) mtim <= mtim + 1;
            m_state <= ref_next(m_state, bus.iniciar, bus.jogada, bus.igual,
                                bus.enderecoIgualRodada, bus.fimR, bus.timeout, bus.fimM);
        end
    end

    // Input driver, 1 time unit after each rising edge.
    initial forever begin
        @(posedge clock);
        #1;
        if (rnd_mode) begin
            bus.iniciar             = ($urandom_range(0, 3) == 0);
            bus.jogada              = ($urandom_range(0, 2) == 0);
            bus.igual               = ($urandom_range(0, 4) != 0);
            bus.enderecoIgualRodada = ($urandom_range(0, 2) == 0);
            bus.fimR                = ($urandom_range(0, 3) == 0);
            bus.timeout             = ($urandom_range(0, 5) == 0);
            bus.fimM                = ($urandom_range(0, 1) == 0);
        end else begin
            bus.enderecoIgualRodada = (addr == rnd);
            bus.fimR                = (rnd == 15);
            bus.fimM                = (mtim >= 2);
            bus.igual               = !(rnd == fail_r && addr == fail_a);
            if (m_state == 6) begin
                bus.jogada  = (play_mode == 1) ? ($urandom_range(0, 2) == 0) : (play_mode == 3);
                bus.timeout = (play_mode >= 2);
            end else begin
                bus.jogada  = ($urandom_range(0, 3) == 0);
                bus.timeout = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    initial forever begin
        @(negedge clock);
        check("db_estado", bus.db_estado, m_state[3:0]);
        check("strobes", dut_o, exp_mask(m_state));
        if (bus.contaR === 1'b1) d_cr++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.igual = 1'b1;
        bus.enderecoIgualRodada = 1'b0; bus.fimR = 1'b0; bus.timeout = 1'b0; bus.fimM = 1'b0;

        repeat (2) @(negedge clock);
        check("reset_estado", bus.db_estado, 4'h0);
        check("reset_saidas", dut_o, 14'h0);
        reset = 1'b0;
        @(negedge clock);
        check("inicial_hold", bus.db_estado, 4'h0);

        // Start-up walk: iniciar held 5 cycles, display phase, then waiting for moves.
        base = d_cr;
        bus.iniciar = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check($sformatf("arranque_%0d", i), bus.db_estado, seq[i]);
            if (seq[i] == 3) check($sformatf("arranque_leds_%0d", i), bus.leds_sel, 1'b1);
            if (i == 4) bus.iniciar = 1'b0;
        end

        // All 16 rounds played correctly.
        play_mode = 1;
        wait_state(4'hA, 5000, "vitoria_estado");
        check("vitoria_contaR", d_cr - base, 15);
        check("vitoria_pronto", bus.pronto, 1'b1);
        check("vitoria_ganhou", bus.ganhou, 1'b1);

        // Second move of round 3 wrong.
        fail_r = 2;
        fail_a = 1;
        base = d_cr;
        bus.iniciar = 1'b1;
        @(negedge clock);
        check("reinicio_de_A", bus.db_estado, 4'h1);
        check("reinicio_ganhou", bus.ganhou, 1'b0);
        bus.iniciar = 1'b0;
        wait_state(4'hE, 3000, "derrota_estado");
        check("derrota_perdeu", bus.perdeu, 1'b1);
        check("derrota_ganhou", bus.ganhou, 1'b0);
        check("derrota_contaR", d_cr - base, 2);

        // Restart from fim_perdeu.
        fail_r = -1;
        bus.iniciar = 1'b1;
        @(negedge clock);
        check("reinicio_de_E", bus.db_estado, 4'h1);
        check("reinicio_zeraE", bus.zeraE, 1'b1);
        check("reinicio_zeraR", bus.zeraR, 1'b1);
        check("reinicio_perdeu", bus.perdeu, 1'b0);
        bus.iniciar = 1'b0;

        // Timeout alone, then jogada and timeout together.
        play_mode = 2;
        wait_state(4'hD, 500, "timeout_estado");
        check("timeout_perdeu", bus.perdeu, 1'b1);
        check("timeout_db", bus.db_timeout, 1'b1);
        bus.iniciar = 1'b1;
        play_mode = 3;
        @(negedge clock);
        bus.iniciar = 1'b0;
        wait_state(4'h6, 500, "espera_estado");
        @(negedge clock);
        check("jogada_prioridade", bus.db_estado, 4'h7);

        // Reset pulse during mostra.
        play_mode = 1;
        wait_state(4'h3, 500, "mostra_estado");
        check("mostra_leds", bus.leds_sel, 1'b1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset_async_estado", bus.db_estado, 4'h0);
        check("reset_async_leds", bus.leds_sel, 1'b0);
        check("reset_async_saidas", dut_o, 14'h0);
        bus.iniciar = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("retoma_apos_reset", bus.db_estado, 4'h1);
        bus.iniciar = 1'b0;

        // Fully random inputs with occasional asynchronous reset pulses.
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 check("reset_aleatorio", bus.db_estado, 4'h0);
                #1 reset = 1'b0;
            end
        end
        rnd_mode = 1'b0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
